cc_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one serial CC byte transmitter among `NREQ` subframe buffer producers. Each producer raises a request when its buffer holds a complete subframe. The scheduler grants one producer, routes that buffer's read port to the transmitter, and pulses the transmitter start. It tracks completion through the transmitter busy flag, then acknowledges the producer so the buffer can be refilled. A watchdog aborts grants whose transmitter never starts or never finishes.

---
 rtl/cc_tx_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_cc_tx_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_tx_scheduler.sv
// -----------------------------------------------------------------------------
// cc_tx_scheduler
//
// Round-robin scheduler sharing one serial CC byte transmitter among NREQ
// subframe buffer producers. A producer raises req_i[i] when its buffer holds
// a complete subframe. The scheduler grants one producer, routes that buffer's
// read port to the transmitter, pulses tx_start_o, follows tx_busy_i until the
// frame is done, then pulses ack_o[i] so the buffer can be refilled. A 24-bit
// watchdog aborts grants whose transmitter never starts or never finishes;
// such grants end with err_o pulsed alongside ack_o.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-high
//   req_i            level request per producer, held until its ack
//   ack_o            one-cycle completion pulse, at most one bit set
//   err_o            one-cycle pulse with ack_o when the grant timed out
//   tx_start_o       one-cycle start pulse to the transmitter
//   tx_busy_i        transmitter active flag
//   tx_rdaddress_i   read address driven by the transmitter
//   tx_data_o        byte from the granted buffer back to the transmitter
//   buf_rdaddress_o  shared read address to all buffers
//   buf_rden_o       one-hot read enable of the granted buffer
//   buf_data_i       buffer read data, buffer i in bits [8i+7:8i]
//   grant_id_o       index of the current/last granted requester
//   frames_ok_o      count of frames completed without timeout (wraps)
// -----------------------------------------------------------------------------
module cc_tx_scheduler #(
   parameter int NREQ          = 4,
   parameter int AW            = 12,
   parameter int START_TIMEOUT = 255,
   parameter int FRAME_TIMEOUT = 24'hFFFFFF,
   parameter int GAP_CYCLES    = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_i,
   output logic [NREQ-1:0]     ack_o,
   output logic                err_o,
   output logic                tx_start_o,
   input  logic                tx_busy_i,
   input  logic [AW-1:0]       tx_rdaddress_i,
   output logic [7:0]          tx_data_o,
   output logic [AW-1:0]       buf_rdaddress_o,
   output logic [NREQ-1:0]     buf_rden_o,
   input  logic [8*NREQ-1:0]   buf_data_i,
   output logic [1:0]          grant_id_o,
   output logic [15:0]         frames_ok_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_SEND,
      S_RELEASE,
      S_GAP
   } state_t;

   // Gap counter runs 0..GAP_CYCLES-1, so it only needs to hold GAP_CYCLES-1.
   localparam int              GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [23:0]     START_WD  = 24'(START_TIMEOUT);
   localparam logic [23:0]     FRAME_WD  = 24'(FRAME_TIMEOUT);
   // Last grant at reset is NREQ-1 so the very first search begins at 0.
   localparam logic [1:0]      GRANT_RST = 2'(NREQ - 1);

   state_t            state_q;
   logic [1:0]        grant_id_q;
   logic [1:0]        grant_id_d;
   logic              arb_found;
   logic [23:0]       wd_q;
   logic [GW-1:0]     gap_q;
   logic [NREQ-1:0]   ack_q;
   logic              err_q;
   logic              tx_start_q;
   logic [15:0]       frames_ok_q;
   logic [NREQ-1:0]   grant_onehot;
   logic              rden_active;

   // --------------------------------------------------------------------------
   // Round-robin pick: first requester strictly above the last grant, else the
   // first one at or below it. This is the modulo-NREQ search from grant+1.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      grant_id_d = grant_id_q;
      arb_found  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!arb_found && req_i[i] && (i > int'(grant_id_q))) begin
            arb_found  = 1'b1;
            grant_id_d = 2'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!arb_found && req_i[i] && (i <= int'(grant_id_q))) begin
            arb_found  = 1'b1;
            grant_id_d = 2'(i);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Read-port routing. The address path is a plain wire so the buffers see the
   // transmitter's address with no added latency.
   // --------------------------------------------------------------------------
   always_comb begin
      grant_onehot = '0;
      tx_data_o    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id_q == 2'(i)) begin
            grant_onehot[i] = 1'b1;
            tx_data_o       = buf_data_i[8*i +: 8];
         end
      end
      rden_active = (state_q == S_START) || (state_q == S_WAIT_BUSY) ||
                    (state_q == S_SEND);
      buf_rden_o  = rden_active ? grant_onehot : '0;
   end

   assign buf_rdaddress_o = tx_rdaddress_i;

   // --------------------------------------------------------------------------
   // Control FSM with registered pulse outputs. ack/err are loaded on the edge
   // that enters RELEASE so they are high exactly during the RELEASE cycle;
   // err_q doubles as the timeout flag consulted by the frame counter there.
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_id_q  <= GRANT_RST;
         wd_q        <= '0;
         gap_q       <= '0;
         ack_q       <= '0;
         err_q       <= 1'b0;
         tx_start_q  <= 1'b0;
         frames_ok_q <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every branch below
         // reads the pre-edge values, matching real flip-flop behaviour.
         ack_q      <= '0;
         err_q      <= 1'b0;
         tx_start_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (|req_i) begin
                  grant_id_q <= grant_id_d;
                  wd_q       <= '0;
                  tx_start_q <= 1'b1;
                  state_q    <= S_START;
               end
            end

            S_START: begin
               state_q <= S_WAIT_BUSY;
            end

            S_WAIT_BUSY: begin
               if (tx_busy_i) begin
                  wd_q    <= '0;
                  state_q <= S_SEND;
               end else if (wd_q == START_WD) begin
                  err_q   <= 1'b1;
                  ack_q   <= grant_onehot;
                  state_q <= S_RELEASE;
               end else begin
                  wd_q <= wd_q + 24'd1;
               end
            end

            S_SEND: begin
               // Completion takes priority over the watchdog on the same edge.
               if (!tx_busy_i) begin
                  ack_q   <= grant_onehot;
                  state_q <= S_RELEASE;
               end else if (wd_q == FRAME_WD) begin
                  err_q   <= 1'b1;
                  ack_q   <= grant_onehot;
                  state_q <= S_RELEASE;
               end else begin
                  wd_q <= wd_q + 24'd1;
               end
            end

            S_RELEASE: begin
               if (!err_q) begin
                  frames_ok_q <= frames_ok_q + 16'd1;
               end
               gap_q   <= '0;
               state_q <= S_GAP;
            end

            S_GAP: begin
               // req_i is deliberately ignored here so producers have time to
               // drop the request that was just acknowledged.
               if (gap_q == GAP_LAST) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ack_o       = ack_q;
   assign err_o       = err_q;
   assign tx_start_o  = tx_start_q;
   assign grant_id_o  = grant_id_q;
   assign frames_ok_o = frames_ok_q;

endmodule

// File: tb/tb_cc_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cc_tx_scheduler
//
// Scoreboard bench for cc_tx_scheduler. The driver plays producers and the
// transmitter; each time it issues a request or starts a transmitter episode
// it works out from the scheduling rules (round-robin order, gap length,
// timeout lengths) which grant and which completion must follow and on which
// cycle, and pushes that into a queue. An independent monitor pops and
// compares whenever the DUT raises tx_start or ack.
// -----------------------------------------------------------------------------
module tb_cc_tx_scheduler;

   localparam int NREQ = 4;
   localparam int AW   = 12;
   localparam int ST   = 10;
   localparam int FT   = 100;
   localparam int GAP  = 16;

   logic              clock;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   ack;
   logic              err;
   logic              tx_start;
   logic              tx_busy;
   logic [AW-1:0]     tx_rdaddress;
   logic [7:0]        tx_data;
   logic [AW-1:0]     buf_rdaddress;
   logic [NREQ-1:0]   buf_rden;
   logic [8*NREQ-1:0] buf_data;
   logic [1:0]        grant_id;
   logic [15:0]       frames_ok;

   cc_tx_scheduler #(
      .NREQ(NREQ), .AW(AW), .START_TIMEOUT(ST), .FRAME_TIMEOUT(FT), .GAP_CYCLES(GAP)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .req_i          (req),
      .ack_o          (ack),
      .err_o          (err),
      .tx_start_o     (tx_start),
      .tx_busy_i      (tx_busy),
      .tx_rdaddress_i (tx_rdaddress),
      .tx_data_o      (tx_data),
      .buf_rdaddress_o(buf_rdaddress),
      .buf_rden_o     (buf_rden),
      .buf_data_i     (buf_data),
      .grant_id_o     (grant_id),
      .frames_ok_o    (frames_ok)
   );

   typedef struct { int g; longint c; } start_t;
   typedef struct { int g; bit e; int fok; longint c; } ack_t;

   start_t start_q[$];
   ack_t   ack_q[$];

   int     tests = 0;
   int     fails = 0;
   longint cyc   = 0;

   // Reference-model state
   int     last_grant   = NREQ - 1;
   longint last_ack_cyc = -1000;
   longint req_cyc      = 0;
   int     frames_exp   = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // Buffer i returns a byte that depends on both its index and the address,
   // so wrong buffer selection or wrong address routing both show up.
   function automatic logic [7:0] exp_byte(input int i, input logic [AW-1:0] a);
      return (8'hA0 + 8'(i)) ^ a[7:0];
   endfunction

   always_comb begin
      buf_data = '0;
      for (int i = 0; i < NREQ; i++) buf_data[8*i +: 8] = exp_byte(i, buf_rdaddress);
   end

   function automatic logic [NREQ-1:0] onehot(input int g);
      logic [NREQ-1:0] v;
      v = 4'b0001;
      return v << g;
   endfunction

   // Round-robin rule: first set bit searching from last+1 upward, modulo NREQ.
   function automatic int next_grant(input logic [NREQ-1:0] r, input int last);
      int idx;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (last + k) % NREQ;
         if (r[2'(idx)]) return idx;
      end
      return -1;
   endfunction

   function automatic longint lmax(input longint a, input longint b);
      return (a > b) ? a : b;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag_unexpected(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got 1 expected 0 (cycle %0d)", name, cyc);
   endtask

   task automatic abort(input string name, input longint act, input longint exp);
      tests++;
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   bit              rden_win = 0;
   int              win_g    = 0;
   bit              post_chk = 0;
   int              post_val = 0;
   start_t          mon_se;
   ack_t            mon_ae;

   always @(negedge clock) begin
      if (reset) begin
         rden_win = 0;
         post_chk = 0;
      end else begin
         if (post_chk) begin
            check("frames_ok_after_release", frames_ok, post_val);
            post_chk = 0;
         end
         check("rdaddr_passthrough", buf_rdaddress, tx_rdaddress);
         if (tx_start) begin
            if (start_q.size() == 0) flag_unexpected("tx_start_unexpected");
            else begin
               mon_se = start_q.pop_front();
               check("start_cycle", cyc, mon_se.c);
               check("grant_id", grant_id, mon_se.g);
               rden_win = 1;
               win_g    = mon_se.g;
            end
         end
         if (ack != '0) begin
            rden_win = 0;
            if (ack_q.size() == 0) flag_unexpected("ack_unexpected");
            else begin
               mon_ae = ack_q.pop_front();
               check("ack_vector", ack, onehot(mon_ae.g));
               check("err_flag", err, mon_ae.e);
               check("ack_cycle", cyc, mon_ae.c);
               check("frames_ok_at_ack", frames_ok, mon_ae.fok);
               post_chk = 1;
               post_val = mon_ae.e ? mon_ae.fok : ((mon_ae.fok + 1) & 16'hFFFF);
            end
         end else if (err) begin
            flag_unexpected("err_without_ack");
         end
         check("buf_rden", buf_rden, rden_win ? onehot(win_g) : 4'b0000);
         if (rden_win) check("tx_data", tx_data, exp_byte(win_g, tx_rdaddress));
      end
   end

   // ---------------------------------------------------------------------------
   // Driver helpers (all called just after a rising edge)
   // ---------------------------------------------------------------------------
   task automatic set_req(input logic [NREQ-1:0] v);
      req     = v;
      req_cyc = cyc;
   endtask

   task automatic wait_start(input longint exp_c);
      int guard;
      guard = 0;
      @(negedge clock);
      while (!tx_start && guard < 400) begin
         @(negedge clock);
         guard++;
      end
      if (!tx_start) abort("tx_start_wait", cyc, exp_c);
   endtask

   // mode 0: normal frame, busy rises d cycles after start and lasts len cycles
   // mode 1: transmitter never starts
   // mode 2: transmitter starts after d cycles and never finishes
   task automatic do_frame(input int mode, input int d, input int len,
                           input logic [NREQ-1:0] newbits);
      start_t se;
      ack_t   ae;
      longint s;
      int     guard;
      se.g = next_grant(req, last_grant);
      se.c = lmax(req_cyc + 1, last_ack_cyc + GAP + 2);
      start_q.push_back(se);
      wait_start(se.c);
      s    = cyc;
      ae.g = se.g;
      ae.fok = frames_exp;
      case (mode)
         1:       begin ae.e = 1; ae.c = s + ST + 2;      end
         2:       begin ae.e = 1; ae.c = s + d + FT + 2;  end
         default: begin ae.e = 0; ae.c = s + d + len + 1; end
      endcase
      ack_q.push_back(ae);
      if (!ae.e) frames_exp = (frames_exp + 1) & 16'hFFFF;
      if (mode != 1) begin
         repeat (d) @(posedge clock);
         #1 tx_busy = 1'b1;
      end
      if (mode == 0) begin
         repeat (len) begin
            @(posedge clock);
            #1 tx_rdaddress = AW'($urandom);
         end
         tx_busy = 1'b0;
      end
      guard = 0;
      @(negedge clock);
      while (ack == '0 && guard < ST + FT + 100) begin
         @(negedge clock);
         guard++;
      end
      if (ack == '0) abort("ack_wait", cyc, ae.c);
      last_ack_cyc = ae.c;
      last_grant   = se.g;
      @(posedge clock);
      #1;
      tx_busy      = 1'b0;
      tx_rdaddress = AW'($urandom);
      set_req((req & ~onehot(se.g)) | newbits);
   endtask

   task automatic ensure_req();
      int n;
      logic [NREQ-1:0] v;
      if (req == '0) begin
         n = $urandom_range(0, 30);
         if (n > 0) begin
            repeat (n) @(posedge clock);
            #1;
         end
         v = 4'($urandom_range(1, 15));
         set_req(v);
      end
   endtask

   task automatic reset_mid_send(input bit with0);
      start_t se;
      logic [NREQ-1:0] r;
      set_req(4'b0010);
      se.g = 1;
      se.c = lmax(req_cyc + 1, last_ack_cyc + GAP + 2);
      start_q.push_back(se);
      wait_start(se.c);
      repeat (2) @(posedge clock);
      #1 tx_busy = 1'b1;
      repeat (6) @(posedge clock);
      #2 reset = 1'b1;
      r = with0 ? 4'b0011 : 4'b0010;
      req = r;
      #1;
      check("rst_ack", ack, 0);
      check("rst_err", err, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_buf_rden", buf_rden, 0);
      check("rst_grant_id", grant_id, NREQ - 1);
      check("rst_frames_ok", frames_ok, 0);
      check("rst_tx_data", tx_data, exp_byte(NREQ - 1, tx_rdaddress));
      repeat (2) @(posedge clock);
      #1;
      tx_busy      = 1'b0;
      reset        = 1'b0;
      last_grant   = NREQ - 1;
      last_ack_cyc = -1000;
      frames_exp   = 0;
      set_req(r);
      do_frame(0, $urandom_range(1, 8), $urandom_range(1, 40), 4'b0000);
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int mode;
      int r;
      reset        = 1'b1;
      req          = '0;
      tx_busy      = 1'b0;
      tx_rdaddress = '0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_ack", ack, 0);
      check("reset_err", err, 0);
      check("reset_tx_start", tx_start, 0);
      check("reset_buf_rden", buf_rden, 0);
      check("reset_grant_id", grant_id, NREQ - 1);
      check("reset_frames_ok", frames_ok, 0);
      reset = 1'b0;
      set_req(4'b1111);

      // Fairness: all four held, each re-asserting after its ack.
      for (int k = 0; k < 5; k++) begin
         do_frame(0, $urandom_range(1, 8), $urandom_range(5, 60), onehot(next_grant(req, last_grant)));
      end

      // Single request to producer 2.
      set_req(4'b0100);
      do_frame(0, 2, 90, 4'b0000);

      // Start timeout, then frame timeout followed by a normal grant.
      set_req(4'b1000);
      do_frame(1, 0, 0, 4'b0000);
      set_req(4'b0010);
      do_frame(2, 3, 0, 4'b0001);
      do_frame(0, 1, 30, 4'b0000);

      // Randomised traffic.
      for (int k = 0; k < 40; k++) begin
         ensure_req();
         r    = $urandom_range(0, 9);
         mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
         do_frame(mode, $urandom_range(1, 8), $urandom_range(1, 80),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      end

      // Reset in the middle of a frame for requester 1.
      reset_mid_send(1'b0);
      reset_mid_send(1'b1);

      while (req != '0) do_frame(0, 2, 10, 4'b0000);

      repeat (GAP + 5) @(posedge clock);
      #1;
      check("start_queue_drained", start_q.size(), 0);
      check("ack_queue_drained", ack_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #600000;
      fails++;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "simulation time limit");
   end

endmodule
